// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encoding and iteration count for the EX-stage multiply/divide unit.
package muldiv_pkg;

  localparam logic [4:0] OP_MULT  = 5'd20;
  localparam logic [4:0] OP_MULTU = 5'd21;
  localparam logic [4:0] OP_DIV   = 5'd22;
  localparam logic [4:0] OP_DIVU  = 5'd23;

  localparam int ITER = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply, restoring shift-subtract for divide.
// The divide path only exists when MULDIV_DIV_EN is defined.
module muldiv_step (
`ifdef MULDIV_DIV_EN
  input  logic        is_div_i,
`endif
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] opb_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [32:0] sum;
`ifdef MULDIV_DIV_EN
  logic [32:0] shifted;
`endif

  always_comb begin
    // Multiply: {hi,lo} holds partial product and remaining multiplier bits.
    sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opb_i} : 33'd0);
    hi_o = sum[32:1];
    lo_o = {sum[0], lo_i[31:1]};
`ifdef MULDIV_DIV_EN
    shifted = {hi_i, lo_i[31]};
    if (is_div_i) begin
      // Partial remainder stays below the divisor, so the 32-bit difference is exact.
      if (shifted >= {1'b0, opb_i}) begin
        hi_o = shifted[31:0] - opb_i;
        lo_o = {lo_i[30:0], 1'b1};
      end else begin
        hi_o = shifted[31:0];
        lo_o = {lo_i[30:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/pipeline_muldiv_ex.sv
// Iterative EX-stage MULT/MULTU (and DIV/DIVU with MULDIV_DIV_EN) unit: 32 RUN cycles plus a
// FIX cycle for sign correction; stalls the front of the pipeline while busy.
module pipeline_muldiv_ex
  import muldiv_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [4:0]  ALUOp,
  input  logic [31:0] OpA,
  input  logic [31:0] OpB,
  output logic        Busy,
  output logic        Stall,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        DivByZero
);

  localparam logic [5:0] LAST_CNT = 6'(ITER - 1);

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic        busy_q, done_q;
  logic [31:0] acc_hi_q, acc_lo_q, opb_q;
  logic [31:0] hi_q, lo_q;
  logic        neg_lo_q;
`ifdef MULDIV_DIV_EN
  logic        op_div_q, neg_hi_q, div0_q, dbz_q;
  logic        is_div_op;
`endif

  logic        op_valid, op_signed, sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic [31:0] step_hi_d, step_lo_d;
  logic [63:0] prod_d;
  logic [31:0] fix_hi_d, fix_lo_d;

  always_comb begin
    op_valid  = (ALUOp == OP_MULT) || (ALUOp == OP_MULTU);
    op_signed = (ALUOp == OP_MULT) || (ALUOp == OP_DIV);
`ifdef MULDIV_DIV_EN
    is_div_op = (ALUOp == OP_DIV) || (ALUOp == OP_DIVU);
    op_valid  = op_valid || is_div_op;
`endif
    sign_a = op_signed & OpA[31];
    sign_b = op_signed & OpB[31];
    // |-2^31| = 2^31 is still representable as an unsigned 32-bit magnitude, so no trap.
    mag_a  = sign_a ? (32'd0 - OpA) : OpA;
    mag_b  = sign_b ? (32'd0 - OpB) : OpB;
  end

  muldiv_step u_step (
`ifdef MULDIV_DIV_EN
    .is_div_i (op_div_q),
`endif
    .hi_i     (acc_hi_q),
    .lo_i     (acc_lo_q),
    .opb_i    (opb_q),
    .hi_o     (step_hi_d),
    .lo_o     (step_lo_d)
  );

  always_comb begin
    prod_d   = {acc_hi_q, acc_lo_q};
    if (neg_lo_q) prod_d = 64'd0 - prod_d;
    fix_hi_d = prod_d[63:32];
    fix_lo_d = prod_d[31:0];
`ifdef MULDIV_DIV_EN
    if (op_div_q) begin
      // Quotient truncates toward zero; remainder follows the dividend sign.
      fix_lo_d = neg_lo_q ? (32'd0 - acc_lo_q) : acc_lo_q;
      fix_hi_d = neg_hi_q ? (32'd0 - acc_hi_q) : acc_hi_q;
      if (div0_q) fix_lo_d = 32'hFFFF_FFFF;
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 6'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      acc_hi_q <= 32'd0;
      acc_lo_q <= 32'd0;
      opb_q    <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      neg_lo_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      op_div_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      dbz_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Start && op_valid) begin
            state_q  <= ST_RUN;
            busy_q   <= 1'b1;
            cnt_q    <= 6'd0;
            acc_hi_q <= 32'd0;
            neg_lo_q <= sign_a ^ sign_b;
`ifdef MULDIV_DIV_EN
            op_div_q <= is_div_op;
            neg_hi_q <= sign_a;
            div0_q   <= is_div_op && (OpB == 32'd0);
            dbz_q    <= 1'b0;
            if (is_div_op) begin
              acc_lo_q <= mag_a;
              opb_q    <= mag_b;
            end else begin
              acc_lo_q <= mag_b;
              opb_q    <= mag_a;
            end
`else
            acc_lo_q <= mag_b;
            opb_q    <= mag_a;
`endif
          end
        end
        ST_RUN: begin
          acc_hi_q <= step_hi_d;
          acc_lo_q <= step_lo_d;
          cnt_q    <= cnt_q + 6'd1;
          if (cnt_q == LAST_CNT) state_q <= ST_FIX;
        end
        ST_FIX: begin
          hi_q    <= fix_hi_d;
          lo_q    <= fix_lo_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
`ifdef MULDIV_DIV_EN
          dbz_q   <= div0_q;
`endif
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy  = busy_q;
  assign Stall = busy_q | (Start & op_valid & (state_q == ST_IDLE));
  assign Done  = done_q;
  assign Hi    = hi_q;
  assign Lo    = lo_q;
`ifdef MULDIV_DIV_EN
  assign DivByZero = dbz_q;
`else
  assign DivByZero = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_muldiv_ex.sv
// Self-checking bench for pipeline_muldiv_ex: directed table, multi-cycle corner sequences and
// random operations against an arithmetic reference model.
module tb_pipeline_muldiv_ex;
  import muldiv_pkg::*;

  logic        Clk, Reset, Start;
  logic [4:0]  ALUOp;
  logic [31:0] OpA, OpB;
  logic        Busy, Stall, Done, DivByZero;
  logic [31:0] Hi, Lo;

  pipeline_muldiv_ex dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .ALUOp     (ALUOp),
    .OpA       (OpA),
    .OpB       (OpB),
    .Busy      (Busy),
    .Stall     (Stall),
    .Done      (Done),
    .Hi        (Hi),
    .Lo        (Lo),
    .DivByZero (DivByZero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] last_hi = 32'd0, last_lo = 32'd0;
  logic        last_dbz = 1'b0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
  } vec_t;
  vec_t tbl[13];
  logic [31:0] corner[5];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s %s: got %h expected %h", tag, what, act, exp);
    end
  endtask

  function automatic logic op_enabled(input logic [4:0] op);
`ifdef MULDIV_DIV_EN
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`else
    return (op == OP_MULT) || (op == OP_MULTU);
`endif
  endfunction

  function automatic void ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dbz = 1'b0;
    p   = 64'd0;
    case (op)
      OP_MULT:  p = 64'(sa * sb);
      OP_MULTU: p = {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == 32'd0) begin p = {a, 32'hFFFF_FFFF}; dbz = 1'b1; end
        else begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
      end
      OP_DIVU: begin
        if (b == 32'd0) begin p = {a, 32'hFFFF_FFFF}; dbz = 1'b1; end
        else p = {a % b, a / b};
      end
      default: p = 64'd0;
    endcase
    hi = p[63:32];
    lo = p[31:0];
  endfunction

  // Issue one op and wait (bounded) for Done; returns latency, stall cycles and DivByZero after E0.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int stalls, output logic d0);
    ALUOp = op; OpA = a; OpB = b; Start = 1'b1;
    #1;
    stalls = Stall ? 1 : 0;
    tick();
    Start = 1'b0;
    d0  = DivByZero;
    lat = 1;
    while (!Done && lat < 60) begin
      if (Stall) stalls++;
      tick();
      lat++;
    end
  endtask

  task automatic apply(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input logic edbz, input string tag);
    int lat, stalls;
    logic d0;
    if (op_enabled(op)) begin
      do_op(op, a, b, lat, stalls, d0);
      chk(tag, "latency", 32'(lat), 32'd34);
      chk(tag, "stall_cycles", 32'(stalls), 32'd34);
      chk(tag, "Hi", Hi, eh);
      chk(tag, "Lo", Lo, el);
      chk(tag, "DivByZero", 32'(DivByZero), 32'(edbz));
      chk(tag, "dbz_after_start", 32'(d0), 32'd0);
      chk(tag, "done_stall", 32'(Stall), 32'd0);
      chk(tag, "done_busy", 32'(Busy), 32'd0);
      last_hi = eh; last_lo = el; last_dbz = edbz;
    end else begin
      ALUOp = op; OpA = a; OpB = b; Start = 1'b1;
      #1;
      chk(tag, "ignored_stall", 32'(Stall), 32'd0);
      tick();
      Start = 1'b0;
      chk(tag, "ignored_busy", 32'(Busy), 32'd0);
      tick();
      tick();
      chk(tag, "ignored_done", 32'(Done), 32'd0);
      chk(tag, "ignored_Hi", Hi, last_hi);
      chk(tag, "ignored_Lo", Lo, last_lo);
      chk(tag, "ignored_dbz", 32'(DivByZero), 32'(last_dbz));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, dn;
    logic [4:0]  rop;
    logic [31:0] ra, rb, eh, el;
    logic        ed;

    tbl[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'd2,          32'd1,         32'hFFFF_FFFE, 1'b0};
    tbl[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    tbl[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    tbl[3]  = '{OP_DIVU,  32'd100,       32'd7,          32'd2,         32'd14,        1'b0};
    tbl[4]  = '{OP_DIVU,  32'd5,         32'd0,          32'd5,         32'hFFFF_FFFF, 1'b1};
    tbl[5]  = '{OP_MULTU, 32'd3,         32'd4,          32'd0,         32'd12,        1'b0};
    tbl[6]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000, 1'b0};
    tbl[7]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'd0,         1'b0};
    tbl[8]  = '{OP_MULT,  32'h8000_0000, 32'd1,          32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
    tbl[9]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD, 1'b0};
    tbl[10] = '{OP_DIV,   32'hFFFF_FFF8, 32'd0,          32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1};
    tbl[11] = '{5'd0,     32'd9,         32'd9,          32'd0,         32'd0,         1'b0};
    tbl[12] = '{5'd24,    32'd9,         32'd9,          32'd0,         32'd0,         1'b0};
    corner[0] = 32'd0; corner[1] = 32'd1; corner[2] = 32'h8000_0000;
    corner[3] = 32'hFFFF_FFFF; corner[4] = 32'h7FFF_FFFF;

    Reset = 1'b1; Start = 1'b0; ALUOp = 5'd0; OpA = 32'd0; OpB = 32'd0;
    repeat (3) tick();
    Reset = 1'b0;
    #1;
    chk("reset", "Busy", 32'(Busy), 32'd0);
    chk("reset", "Stall", 32'(Stall), 32'd0);
    chk("reset", "Done", 32'(Done), 32'd0);
    chk("reset", "Hi", Hi, 32'd0);
    chk("reset", "Lo", Lo, 32'd0);
    chk("reset", "DivByZero", 32'(DivByZero), 32'd0);

    // Directed table; consecutive entries start in the previous Done cycle.
    for (int i = 0; i < 13; i++)
      apply(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].dbz, $sformatf("tbl%0d", i));
    tick();
    chk("tbl_end", "done_pulse_width", 32'(Done), 32'd0);

    // Reset in RUN cycle 10 aborts the operation.
    ALUOp = OP_MULTU; OpA = 32'h1234_5678; OpB = 32'd9; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (9) tick();
    chk("abort", "busy_before", 32'(Busy), 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("abort", "Busy", 32'(Busy), 32'd0);
    chk("abort", "Hi", Hi, 32'd0);
    chk("abort", "Lo", Lo, 32'd0);
    chk("abort", "Done", 32'(Done), 32'd0);
    dn = 0;
    repeat (40) begin tick(); if (Done) dn++; end
    chk("abort", "late_done", 32'(dn), 32'd0);
    last_hi = 32'd0; last_lo = 32'd0; last_dbz = 1'b0;

    // Reset wins over a simultaneous Start.
    Reset = 1'b1; ALUOp = OP_MULT; OpA = 32'd3; OpB = 32'd3; Start = 1'b1;
    tick();
    Reset = 1'b0; Start = 1'b0;
    chk("rst_prio", "Busy", 32'(Busy), 32'd0);
    tick();
    chk("rst_prio", "Busy2", 32'(Busy), 32'd0);

    // Start while Busy is ignored.
    ALUOp = OP_MULTU; OpA = 32'd6; OpB = 32'd7; Start = 1'b1;
    tick();
    Start = 1'b0;
    lat = 1;
    repeat (4) begin tick(); lat++; end
    ALUOp = OP_MULTU; OpA = 32'd100; OpB = 32'd100; Start = 1'b1;
    #1;
    chk("busy_start", "Stall", 32'(Stall), 32'd1);
    tick();
    lat++;
    Start = 1'b0;
    while (!Done && lat < 60) begin tick(); lat++; end
    chk("busy_start", "latency", 32'(lat), 32'd34);
    chk("busy_start", "Hi", Hi, 32'd0);
    chk("busy_start", "Lo", Lo, 32'd42);
    dn = 0;
    repeat (40) begin tick(); if (Done) dn++; end
    chk("busy_start", "extra_done", 32'(dn), 32'd0);
    last_hi = 32'd0; last_lo = 32'd42;

    // Back-to-back: second Start lands in the first op's Done cycle.
    apply(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0, "b2b_a");
    apply(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, "b2b_b");

    for (int i = 0; i < 40; i++) begin
      rop = OP_MULT + 5'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom();
      rb  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom();
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      ref_model(rop, ra, rb, eh, el, ed);
      apply(rop, ra, rb, eh, el, ed, $sformatf("rnd%0d_op%0d", i, rop));
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
